// File: rtl/g729_basic_pkg.sv
// G.729 basic-operator word types and saturation limits
// shared by the fixed-point datapath units.
package g729_basic_pkg;

  typedef logic signed [15:0] word16;
  typedef logic signed [31:0] long32;

  localparam long32 MAX_32 = 32'h7FFFFFFF;
  localparam long32 MIN_32 = 32'h80000000;
  localparam word16 MIN_16 = 16'h8000;

endpackage

// File: rtl/l_mult_core.sv
// L_mult: doubled signed 16x16 product, saturating
// the single unrepresentable case (-1.0 * -1.0).
module l_mult_core
  import g729_basic_pkg::*;
(
  input  word16 a,
  input  word16 b,
  output long32 product,
  output logic  overflow
);

  long32 prod;

  assign prod     = a * b;
  assign overflow = (a == MIN_16) && (b == MIN_16);
  assign product  = overflow ? MAX_32 : (prod <<< 1);

endmodule

// File: rtl/l_mult_mac_msu.sv
// L_mult / L_mac / L_msu as independent combinational
// channels, plus a sticky overflow flag.
module l_mult_mac_msu
  import g729_basic_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mult_a,
  input  logic [15:0] mult_b,
  output logic [31:0] mult_product,
  output logic        mult_overflow,
  input  logic [15:0] mac_a,
  input  logic [15:0] mac_b,
  input  logic [31:0] mac_c,
  output logic [31:0] mac_out,
  output logic        mac_overflow,
  input  logic [15:0] msu_a,
  input  logic [15:0] msu_b,
  input  logic [31:0] msu_c,
  output logic [31:0] msu_out,
  output logic        msu_overflow,
  input  logic        ovf_clear,
  output logic        ovf_sticky
);

  long32       macM;
  long32       msuM;
  logic        macMulOvf;
  logic        msuMulOvf;
  logic [32:0] macSum;
  logic [32:0] msuDiff;
  logic        macAddOvf;
  logic        msuSubOvf;

  l_mult_core uMult (
    .a        (mult_a),
    .b        (mult_b),
    .product  (mult_product),
    .overflow (mult_overflow)
  );

  l_mult_core uMacMul (
    .a        (mac_a),
    .b        (mac_b),
    .product  (macM),
    .overflow (macMulOvf)
  );

  l_mult_core uMsuMul (
    .a        (msu_a),
    .b        (msu_b),
    .product  (msuM),
    .overflow (msuMulOvf)
  );

  // 33-bit result saturates when bits 32 and 31 disagree
  assign macSum    = {mac_c[31], mac_c} + {macM[31], macM};
  assign msuDiff   = {msu_c[31], msu_c} - {msuM[31], msuM};
  assign macAddOvf = macSum[32] ^ macSum[31];
  assign msuSubOvf = msuDiff[32] ^ msuDiff[31];

  always_comb begin
    mac_out = macSum[31:0];
    if (macAddOvf)
      mac_out = macSum[32] ? MIN_32 : MAX_32;
  end

  always_comb begin
    msu_out = msuDiff[31:0];
    if (msuSubOvf)
      msu_out = msuDiff[32] ? MIN_32 : MAX_32;
  end

  assign mac_overflow = macMulOvf | macAddOvf;
  assign msu_overflow = msuMulOvf | msuSubOvf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf_sticky <= 1'b0;
    else if (ovf_clear)
      ovf_sticky <= 1'b0;
    else
      ovf_sticky <= ovf_sticky | mult_overflow
                  | mac_overflow | msu_overflow;
  end

endmodule

// File: tb/tb_l_mult_mac_msu.sv
// Bench for l_mult_mac_msu: directed G.729 vectors
// and random operands against an arithmetic model.
module tb_l_mult_mac_msu;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mult_a, mult_b;
  logic [31:0] mult_product;
  logic        mult_overflow;
  logic [15:0] mac_a, mac_b;
  logic [31:0] mac_c;
  logic [31:0] mac_out;
  logic        mac_overflow;
  logic [15:0] msu_a, msu_b;
  logic [31:0] msu_c;
  logic [31:0] msu_out;
  logic        msu_overflow;
  logic        ovf_clear;
  logic        ovf_sticky;

  int checks = 0;
  int errors = 0;

  logic [31:0] eMult, eMac, eMsu;
  logic        oMult, oMac, oMsu;
  logic        eSticky;

  localparam longint MAXL = 64'sd2147483647;
  localparam longint MINL = -64'sd2147483648;

  always #5 clk = ~clk;

  l_mult_mac_msu dut (
    .clk           (clk),
    .reset         (reset),
    .mult_a        (mult_a),
    .mult_b        (mult_b),
    .mult_product  (mult_product),
    .mult_overflow (mult_overflow),
    .mac_a         (mac_a),
    .mac_b         (mac_b),
    .mac_c         (mac_c),
    .mac_out       (mac_out),
    .mac_overflow  (mac_overflow),
    .msu_a         (msu_a),
    .msu_b         (msu_b),
    .msu_c         (msu_c),
    .msu_out       (msu_out),
    .msu_overflow  (msu_overflow),
    .ovf_clear     (ovf_clear),
    .ovf_sticky    (ovf_sticky)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void lMult(input logic [15:0] a, b,
                                output logic [31:0] r,
                                output logic o);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b)) * 2;
    o = (p > MAXL);
    r = o ? 32'h7FFFFFFF : p[31:0];
  endfunction

  function automatic void lAcc(input logic [31:0] c,
                               input logic [15:0] a, b,
                               input bit sub,
                               output logic [31:0] r,
                               output logic o);
    logic [31:0] m;
    logic        mo;
    longint      s;
    lMult(a, b, m, mo);
    s = sub ? longint'($signed(c)) - longint'($signed(m))
            : longint'($signed(c)) + longint'($signed(m));
    o = mo;
    if (s > MAXL) begin
      r = 32'h7FFFFFFF;
      o = 1'b1;
    end else if (s < MINL) begin
      r = 32'h80000000;
      o = 1'b1;
    end else begin
      r = s[31:0];
    end
  endfunction

  task automatic drive(input logic [15:0] ma, mb,
                       input logic [31:0] ac,
                       input logic [15:0] aa, ab,
                       input logic [31:0] sc,
                       input logic [15:0] sa, sb,
                       input logic clr);
    mult_a = ma; mult_b = mb;
    mac_c = ac; mac_a = aa; mac_b = ab;
    msu_c = sc; msu_a = sa; msu_b = sb;
    ovf_clear = clr;
    lMult(ma, mb, eMult, oMult);
    lAcc(ac, aa, ab, 1'b0, eMac, oMac);
    lAcc(sc, sa, sb, 1'b1, eMsu, oMsu);
    #1;
  endtask

  task automatic checkComb(input string tag);
    check({tag, ".mult"}, mult_product, eMult);
    check({tag, ".multO"}, {31'b0, mult_overflow}, {31'b0, oMult});
    check({tag, ".mac"}, mac_out, eMac);
    check({tag, ".macO"}, {31'b0, mac_overflow}, {31'b0, oMac});
    check({tag, ".msu"}, msu_out, eMsu);
    check({tag, ".msuO"}, {31'b0, msu_overflow}, {31'b0, oMsu});
  endtask

  // model flag advances on the edge from the inputs held over it
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset)
      eSticky = ovf_clear ? 1'b0 : (eSticky | oMult | oMac | oMsu);
    #1;
    check({tag, ".sticky"}, {31'b0, ovf_sticky}, {31'b0, eSticky});
  endtask

  function automatic logic [15:0] rWord();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rLong();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'h7FFFFFFF;
      2: return 32'($urandom_range(0, 255)) - 32'd128;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    eSticky = 1'b0;
    drive(16'h8000, 16'h8000, 0, 0, 0, 0, 0, 0, 1'b0);
    tick("rst0");
    tick("rst1");
    @(negedge clk);
    reset = 1'b1;

    drive(16'h4000, 16'h4000, 32'h10, 16'h3, 16'h4,
          32'h100, 16'h10, 16'h2, 1'b0);
    check("d1.mult", mult_product, 32'h20000000);
    check("d1.mac", mac_out, 32'h00000028);
    check("d1.msu", msu_out, 32'h000000C0);
    checkComb("d1");
    tick("d1");

    drive(16'hFFFF, 16'h0001, 32'h7FFFFFF0, 16'h0100, 16'h0100,
          32'h80000000, 16'h1, 16'h1, 1'b0);
    check("d2.mult", mult_product, 32'hFFFFFFFE);
    check("d2.mac", mac_out, 32'h7FFFFFFF);
    check("d2.macO", {31'b0, mac_overflow}, 32'd1);
    check("d2.msu", msu_out, 32'h80000000);
    check("d2.msuO", {31'b0, msu_overflow}, 32'd1);
    checkComb("d2");
    tick("d2");
    check("d2.set", {31'b0, ovf_sticky}, 32'd1);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    tick("clr");
    check("clr.zero", {31'b0, ovf_sticky}, 32'd0);

    drive(16'h8000, 16'h8000, 32'hFFFFFFFF, 16'h8000, 16'h8000,
          32'h0, 16'h8000, 16'h8000, 1'b1);
    check("d3.mult", mult_product, 32'h7FFFFFFF);
    check("d3.multO", {31'b0, mult_overflow}, 32'd1);
    check("d3.mac", mac_out, 32'h7FFFFFFE);
    check("d3.macO", {31'b0, mac_overflow}, 32'd1);
    check("d3.msu", msu_out, 32'h80000001);
    check("d3.msuO", {31'b0, msu_overflow}, 32'd1);
    tick("d3");
    check("clrPrio", {31'b0, ovf_sticky}, 32'd0);

    drive(16'h8000, 16'h8000, 0, 0, 0, 0, 0, 0, 1'b0);
    tick("mset");
    check("mset.one", {31'b0, ovf_sticky}, 32'd1);
    drive(16'h0002, 16'h0003, 0, 0, 0, 0, 0, 0, 1'b0);
    tick("hold");
    check("hold.one", {31'b0, ovf_sticky}, 32'd1);

    // async reset between edges; data outputs stay put
    @(negedge clk);
    reset = 1'b0;
    #1;
    eSticky = 1'b0;
    check("arst.sticky", {31'b0, ovf_sticky}, 32'd0);
    check("arst.mult", mult_product, 32'h0000000C);
    checkComb("arst");
    @(negedge clk);
    reset = 1'b1;
    tick("post");

    for (int i = 0; i < 300; i++) begin
      drive(rWord(), rWord(), rLong(), rWord(), rWord(),
            rLong(), rWord(), rWord(),
            $urandom_range(0, 7) == 0);
      checkComb("rnd");
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
